// File: rtl/spi_dep_pkg.sv
// Shared types and limits for the SPI word deserializer front-end.
package spi_dep_pkg;
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int SPI_MAX_WIDTH = 32;
endpackage

// File: rtl/spi_dep_edge_detect.sv
// Registers a synchronized 1-bit signal and flags its rising/falling edges.
module spi_dep_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);
    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= RESET_VAL;
        else     sig_q <= sig;
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;
endmodule

// File: rtl/spi_dep_spi_word_deserializer.sv
// SPI mode-0 target: deserializes MOSI into words (valid/ready) and serializes tx words onto MISO.
module spi_dep_spi_word_deserializer
    import spi_dep_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MSB_FIRST  = 1,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  sck_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  overrun_o,
    output logic                  frame_err_o
);
    localparam int CNT_W = $clog2(SPI_MAX_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall;

    spi_dep_edge_detect #(.RESET_VAL(1'b0)) u_sck_edge (
        .clk  (clk_i),
        .rst  (reset_i),
        .sig  (sck_i),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_dep_edge_detect #(.RESET_VAL(1'b1)) u_cs_edge (
        .clk  (clk_i),
        .rst  (reset_i),
        .sig  (cs_n_i),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    state_e                state, state_d;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] rx_shift, rx_next;
    logic [DATA_WIDTH-1:0] tx_shift, tx_word;
    logic                  load_tx, shift_tx, shift_rx, cnt_clr, frame_err_d;
    logic                  word_end, rx_accept;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Chip-select deassertion outranks any SCK edge seen in the same cycle.
    always_comb begin
        load_tx     = 1'b0;
        shift_tx    = 1'b0;
        shift_rx    = 1'b0;
        cnt_clr     = 1'b0;
        frame_err_d = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                load_tx = cs_fall;
            end
            ACTIVE: begin
                if (cs_rise) begin
                    cnt_clr     = 1'b1;
                    frame_err_d = (bit_cnt != '0);
                end else if (sck_rise) begin
                    shift_rx = 1'b1;
                end else if (sck_fall) begin
                    if (bit_cnt == '0 && word_done) load_tx  = 1'b1;
                    else                            shift_tx = 1'b1;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    assign word_end  = shift_rx && (bit_cnt == LAST_BIT);
    assign rx_accept = !rx_valid_o || rx_ready_i;
    assign rx_next   = (MSB_FIRST != 0) ? {rx_shift[DATA_WIDTH-2:0], mosi_i}
                                        : {mosi_i, rx_shift[DATA_WIDTH-1:1]};
    assign tx_word   = tx_valid_i ? tx_data_i : TX_IDLE;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bit_cnt   <= '0;
            word_done <= 1'b0;
            rx_shift  <= '0;
        end else begin
            if (cnt_clr) begin
                bit_cnt   <= '0;
                word_done <= 1'b0;
            end else if (shift_rx) begin
                bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
                if (word_end) word_done <= 1'b1;
            end
            if (shift_rx) rx_shift <= rx_next;
        end
    end

    // Single holding register: a word arriving while the previous one is unclaimed is lost.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= frame_err_d;
            if (word_end && rx_accept) begin
                rx_data_o  <= rx_next;
                rx_valid_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
            if (word_end && !rx_accept) overrun_o <= 1'b1;
        end
    end

    // MISO is updated on the load itself so the first bit is settled before the first SCK rise.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_shift   <= '0;
            miso_o     <= 1'b0;
            tx_ready_o <= 1'b0;
        end else begin
            tx_ready_o <= load_tx && tx_valid_i;
            if (load_tx) begin
                tx_shift <= tx_word;
                miso_o   <= (MSB_FIRST != 0) ? tx_word[DATA_WIDTH-1] : tx_word[0];
            end else if (shift_tx) begin
                if (MSB_FIRST != 0) begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    miso_o   <= tx_shift[DATA_WIDTH-2];
                end else begin
                    tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
                    miso_o   <= tx_shift[1];
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_dep_spi_word_deserializer.sv
// Directed bench: an 8-bit MSB-first target with TX_IDLE=FF and a 16-bit LSB-first target.
module tb_spi_dep_spi_word_deserializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        sck = 1'b0, cs_n = 1'b1, mosi = 1'b0, rx_ready = 1'b0, tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        miso, rx_valid, tx_ready, overrun, frame_err;
    logic [7:0]  rx_data;

    logic        sck2 = 1'b0, cs2_n = 1'b1, mosi2 = 1'b0, rx_ready2 = 1'b0, tx_valid2 = 1'b0;
    logic [15:0] tx_data2 = 16'h0000;
    logic        miso2, rx_valid2, tx_ready2, overrun2, frame_err2;
    logic [15:0] rx_data2;

    int checks = 0;
    int errors = 0;
    int txr_cnt = 0, fe_cnt = 0, txr2_cnt = 0;

    always #5 clk = ~clk;

    spi_dep_spi_word_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .TX_IDLE(8'hFF)) dut8 (
        .clk_i(clk), .reset_i(rst), .sck_i(sck), .cs_n_i(cs_n), .mosi_i(mosi),
        .miso_o(miso), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .overrun_o(overrun), .frame_err_o(frame_err)
    );

    spi_dep_spi_word_deserializer #(.DATA_WIDTH(16), .MSB_FIRST(0)) dut16 (
        .clk_i(clk), .reset_i(rst), .sck_i(sck2), .cs_n_i(cs2_n), .mosi_i(mosi2),
        .miso_o(miso2), .rx_data_o(rx_data2), .rx_valid_o(rx_valid2), .rx_ready_i(rx_ready2),
        .tx_data_i(tx_data2), .tx_valid_i(tx_valid2), .tx_ready_o(tx_ready2),
        .overrun_o(overrun2), .frame_err_o(frame_err2)
    );

    // Pulse counters let the bench verify one-cycle pulses without polling every cycle.
    always @(negedge clk) begin
        if (tx_ready)  txr_cnt  <= txr_cnt + 1;
        if (frame_err) fe_cnt   <= fe_cnt + 1;
        if (tx_ready2) txr2_cnt <= txr2_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        clks(4);
    endtask

    task automatic cs_high();
        clks(4);
        cs_n = 1'b1;
        clks(4);
    endtask

    // One SCK period at 8:1; MISO is sampled just before the rising edge, as a master would.
    task automatic sck_bit(input logic b, output logic m);
        mosi = b;
        clks(4);
        m = miso;
        sck = 1'b1;
        clks(4);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, output logic [7:0] m);
        logic mb;
        for (int i = 7; i >= 0; i--) begin
            sck_bit(w[i], mb);
            m[i] = mb;
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        clks(1);
        rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] rx_word;
        logic       tx_valid;
        logic [7:0] tx_data;
        logic [7:0] exp_miso;
        int         exp_txr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0]  m8;
        logic [15:0] m16;
        logic [15:0] w16;
        logic        mb;
        int          txr0, fe0;

        vecs[0] = '{8'hA5, 1'b1, 8'h3C, 8'h3C, 1};
        vecs[1] = '{8'h00, 1'b1, 8'h81, 8'h81, 1};
        vecs[2] = '{8'hC3, 1'b0, 8'h12, 8'hFF, 0};
        vecs[3] = '{8'h7E, 1'b1, 8'hA5, 8'hA5, 1};
        vecs[4] = '{8'hFF, 1'b0, 8'h00, 8'hFF, 0};

        clks(3);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_rx_valid16", {31'd0, rx_valid2}, 32'd0);
        rst = 1'b0;
        clks(3);

        for (int v = 0; v < 5; v++) begin
            txr0     = txr_cnt;
            tx_valid = vecs[v].tx_valid;
            tx_data  = vecs[v].tx_data;
            cs_low();
            tx_valid = 1'b0;
            for (int i = 7; i >= 1; i--) begin
                sck_bit(vecs[v].rx_word[i], mb);
                m8[i] = mb;
            end
            mosi = vecs[v].rx_word[0];
            clks(4);
            m8[0] = miso;
            sck = 1'b1;
            @(negedge clk);
            check("vec_valid_before_latency", {31'd0, rx_valid}, 32'd0);
            @(negedge clk);
            check("vec_valid_after_latency", {31'd0, rx_valid}, 32'd1);
            check("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[v].rx_word});
            clks(3);
            sck = 1'b0;
            cs_high();
            check("vec_miso_word", {24'd0, m8}, {24'd0, vecs[v].exp_miso});
            check("vec_tx_ready_pulses", txr_cnt - txr0, vecs[v].exp_txr);
            check("vec_overrun", {31'd0, overrun}, 32'd0);
            consume();
            check("vec_valid_dropped", {31'd0, rx_valid}, 32'd0);
        end

        // Three back-to-back words with nobody consuming.
        cs_low();
        send_word(8'h01, m8);
        check("ovr_w1_data", {24'd0, rx_data}, 32'h01);
        check("ovr_w1_overrun", {31'd0, overrun}, 32'd0);
        send_word(8'h02, m8);
        check("ovr_w2_overrun", {31'd0, overrun}, 32'd1);
        check("ovr_w2_data_held", {24'd0, rx_data}, 32'h01);
        send_word(8'h03, m8);
        check("ovr_w3_data_held", {24'd0, rx_data}, 32'h01);
        check("ovr_w3_valid", {31'd0, rx_valid}, 32'd1);
        cs_high();
        consume();
        check("ovr_valid_dropped", {31'd0, rx_valid}, 32'd0);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Partial frame, then a clean frame.
        fe0 = fe_cnt;
        cs_low();
        for (int i = 0; i < 5; i++) sck_bit(i[0], mb);
        cs_high();
        check("ferr_one_pulse", fe_cnt - fe0, 1);
        check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
        cs_low();
        send_word(8'h5A, m8);
        cs_high();
        check("ferr_next_data", {24'd0, rx_data}, 32'h5A);
        check("ferr_next_valid", {31'd0, rx_valid}, 32'd1);
        check("ferr_next_no_err", fe_cnt - fe0, 1);
        consume();

        // Reset in the middle of a frame.
        cs_low();
        for (int i = 0; i < 3; i++) sck_bit(1'b1, mb);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_miso", {31'd0, miso}, 32'd0);
        check("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_overrun", {31'd0, overrun}, 32'd0);
        check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_mid_frame_err", {31'd0, frame_err}, 32'd0);
        cs_n = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(3);
        fe0 = fe_cnt;
        cs_low();
        send_word(8'hC3, m8);
        cs_high();
        check("rst_next_data", {24'd0, rx_data}, 32'hC3);
        check("rst_next_valid", {31'd0, rx_valid}, 32'd1);
        check("rst_next_overrun", {31'd0, overrun}, 32'd0);
        check("rst_next_miso_idle", {24'd0, m8}, 32'hFF);
        check("rst_next_no_err", fe_cnt - fe0, 0);
        consume();

        // 16-bit LSB-first target at clk:SCK = 4:1.
        w16       = 16'h1234;
        txr0      = txr2_cnt;
        tx_valid2 = 1'b1;
        tx_data2  = 16'hBEEF;
        cs2_n     = 1'b0;
        clks(2);
        tx_valid2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mosi2 = w16[i];
            clks(2);
            m16[i] = miso2;
            sck2 = 1'b1;
            clks(2);
            sck2 = 1'b0;
        end
        clks(2);
        cs2_n = 1'b1;
        clks(2);
        check("w16_rx_data", {16'd0, rx_data2}, 32'h1234);
        check("w16_rx_valid", {31'd0, rx_valid2}, 32'd1);
        check("w16_miso_word", {16'd0, m16}, 32'hBEEF);
        check("w16_tx_ready_pulses", txr2_cnt - txr0, 1);
        check("w16_overrun", {31'd0, overrun2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
